// File: rtl/chunked_add_ctrl.sv
// -----------------------------------------------------------------------------
// chunked_add_ctrl
//   Multi-cycle add engine. One operand pair plus carry-in is accepted per
//   valid/ready handshake. The engine then adds CHUNK bits per cycle through a
//   narrow ripple slice, passing the carry from slice to slice. The result is
//   presented on a valid/ready output port. This trades latency for a short
//   carry chain in each cycle.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous active-high reset
//   in_valid   in   1      operand pair available
//   in_ready   out  1      engine can accept operands (state IDLE)
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   cin        in   1      carry into bit 0
//   out_valid  out  1      sum/cout/ovf valid (state DONE)
//   out_ready  in   1      consumer takes the result
//   sum        out  WIDTH  a + b + cin, modulo 2^WIDTH
//   cout       out  1      carry out of bit WIDTH-1
//   ovf        out  1      signed overflow of the add
//   busy       out  1      state != IDLE
// -----------------------------------------------------------------------------
module chunked_add_ctrl #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NCHUNK = WIDTH / CHUNK;
    // Keep the index at least one bit wide so NCHUNK == 1 still elaborates.
    localparam int IDX_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    generate
        if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
            $error("chunked_add_ctrl: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    // Working operand/partial-sum registers carry no control meaning and are
    // always written before being read, so they are left without reset.
    logic [WIDTH-1:0] a_w_q, a_w_d;
    logic [WIDTH-1:0] b_w_q, b_w_d;
    logic [WIDTH-1:0] sum_w_q, sum_w_d;

    // One CHUNK-bit ripple slice; bit CHUNK is the carry into the next slice.
    logic [CHUNK:0] slice;

    always_comb begin
        slice = {1'b0, a_w_q[idx_q*CHUNK +: CHUNK]}
              + {1'b0, b_w_q[idx_q*CHUNK +: CHUNK]}
              + (CHUNK+1)'(carry_q);
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        a_w_d   = a_w_q;
        b_w_d   = b_w_q;
        sum_w_d = sum_w_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_w_d   = a;
                    b_w_d   = b;
                    carry_d = cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_w_d[idx_q*CHUNK +: CHUNK] = slice[CHUNK-1:0];
                carry_d = slice[CHUNK];
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    // Final slice: publish the complete result in one step so
                    // the outputs only ever change on entry to DONE.
                    sum_d   = sum_w_d;
                    cout_d  = slice[CHUNK];
                    ovf_d   = (a_w_q[WIDTH-1] == b_w_q[WIDTH-1]) &&
                              (sum_w_d[WIDTH-1] != a_w_q[WIDTH-1]);
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                // Returning to IDLE here means a new operand can only be
                // accepted on the following cycle.
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        a_w_q   <= a_w_d;
        b_w_q   <= b_w_d;
        sum_w_q <= sum_w_d;
    end

    // Handshake outputs decode the state register directly, so an async reset
    // in DONE drops out_valid immediately.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_chunked_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_chunked_add_ctrl
//   Self-checking bench for chunked_add_ctrl at default parameters. Expected
//   results come from a full-width reference add, pushed to a queue when an
//   operation is accepted and popped when the engine presents its result.
// -----------------------------------------------------------------------------
module tb_chunked_add_ctrl;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    chunked_add_ctrl #(.WIDTH(32), .CHUNK(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                   input logic mc);
        exp_t e;
        logic [W:0] full;
        full   = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (ma[W-1] == mb[W-1]) && (full[W-1] != ma[W-1]);
        return e;
    endfunction

    // Present one operand pair for a single accept edge, then scramble inputs
    // so any late sampling by the DUT shows up as a wrong result.
    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_in_ready: got %b want 1", in_ready);
        end
        sb.push_back(model(ta, tb_v, tc));
        a        = ta;
        b        = tb_v;
        cin      = tc;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        cin      = 1'($urandom);
    endtask

    // Wait for the result (bounded), check latency and value, then handshake.
    task automatic recv(input string name, input int exp_lat);
        int   cyc;
        exp_t e;
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: out_valid never rose within %0d cycles", name, cyc);
            return;
        end
        if (exp_lat > 0) begin
            checks++;
            if (cyc != exp_lat) begin
                errors++;
                $display("FAIL %s_latency: got %0d want %0d", name, cyc, exp_lat);
            end
        end
        e = sb.pop_front();
        checks++;
        if (sum !== e.sum || cout !== e.cout || ovf !== e.ovf) begin
            errors++;
            $display("FAIL %s_result: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                     name, sum, cout, ovf, e.sum, e.cout, e.ovf);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_release: got out_valid=%b in_ready=%b busy=%b want 0 1 0",
                     name, out_valid, in_ready, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || sum !== '0 || cout !== 1'b0 || ovf !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got out_valid=%b sum=%h cout=%b ovf=%b busy=%b want 0 0 0 0 0",
                     out_valid, sum, cout, ovf, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_basic();
        send(32'd5, 32'd2, 1'b0);
        checks++;
        if (sum !== 32'h0000_0000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_outputs_hold: got sum=%h busy=%b want 00000000 1", sum, busy);
        end
        recv("basic_5p2", 4);
        checks++;
        if (sum !== 32'h0000_0007) begin
            errors++;
            $display("FAIL basic_const: got %h want 00000007", sum);
        end
    endtask

    task automatic test_carry_chain();
        send(32'h0000_000F, 32'h0000_FFFF, 1'b0);
        recv("carry_chain", 4);
        checks++;
        if (sum !== 32'h0001_000E) begin
            errors++;
            $display("FAIL carry_chain_const: got %h want 0001000E", sum);
        end
    endtask

    task automatic test_cin();
        send(32'd8, 32'd5, 1'b1);
        recv("cin_small", 4);
        send(32'h1000_0FFF, 32'h0000_FFFF, 1'b1);
        recv("cin_chain", 4);
        checks++;
        if (sum !== 32'h1001_0FFF || cout !== 1'b0) begin
            errors++;
            $display("FAIL cin_chain_const: got sum=%h cout=%b want 10010FFF 0", sum, cout);
        end
    endtask

    task automatic test_wrap_ovf();
        send(32'hFFFF_FFFF, 32'h0, 1'b1);
        recv("wrap", 4);
        checks++;
        if (sum !== 32'h0 || cout !== 1'b1 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL wrap_const: got sum=%h cout=%b ovf=%b want 00000000 1 0", sum, cout, ovf);
        end
        send(32'h7FFF_FFFF, 32'h1, 1'b0);
        recv("ovf_pos", 4);
        checks++;
        if (sum !== 32'h8000_0000 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_const: got sum=%h ovf=%b want 80000000 1", sum, ovf);
        end
        send(32'h8000_0000, 32'h8000_0000, 1'b0);
        recv("ovf_neg", 4);
    endtask

    task automatic test_backpressure();
        exp_t e;
        exp_t e2;
        int   cyc;
        send(32'h1234_5678, 32'h0FED_CBA9, 1'b1);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        e = sb.pop_front();
        // Offer a new operand during DONE; it must wait for the handshake.
        a = 32'hAAAA_0001; b = 32'h5555_0002; cin = 1'b0; in_valid = 1'b1;
        e2 = model(32'hAAAA_0001, 32'h5555_0002, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== e.sum || cout !== e.cout) begin
                errors++;
                $display("FAIL backpressure_hold%0d: got out_valid=%b in_ready=%b sum=%h cout=%b want 1 0 %h %b",
                         i, out_valid, in_ready, sum, cout, e.sum, e.cout);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_no_same_cycle_accept: got out_valid=%b in_ready=%b busy=%b want 0 1 0",
                     out_valid, in_ready, busy);
        end
        sb.push_back(e2);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom;
        recv("backpressure_next", 4);
    endtask

    task automatic test_reset_in_run();
        send(32'h0000_1111, 32'h0000_2222, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || sum !== '0) begin
            errors++;
            $display("FAIL reset_run_async: got out_valid=%b busy=%b sum=%h want 0 0 0",
                     out_valid, busy, sum);
        end
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_run_release: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
        send(32'd3, 32'd4, 1'b0);
        recv("reset_run_next", 4);
    endtask

    task automatic test_reset_in_done();
        send(32'h0000_00FF, 32'h0000_0001, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_done_pre: got out_valid=%b want 1", out_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || sum !== '0) begin
            errors++;
            $display("FAIL reset_done_async: got out_valid=%b sum=%h want 0 0", out_valid, sum);
        end
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   nvalid;
        for (int i = 0; i < 6; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rc;
            ra = $urandom; rb = $urandom; rc = 1'($urandom);
            send(ra, rb, rc);
            recv("b2b_random", 4);
        end
        // Hold both handshakes high: one result every NCHUNK+2 = 6 cycles.
        e = model(32'h0F0F_F0F0, 32'h00FF_FF01, 1'b1);
        a = 32'h0F0F_F0F0; b = 32'h00FF_FF01; cin = 1'b1;
        in_valid = 1'b1; out_ready = 1'b1;
        nvalid = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) begin
                nvalid++;
                checks++;
                if (sum !== e.sum || cout !== e.cout || ovf !== e.ovf) begin
                    errors++;
                    $display("FAIL b2b_stream_result: got sum=%h cout=%b ovf=%b want %h %b %b",
                             sum, cout, ovf, e.sum, e.cout, e.ovf);
                end
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if (nvalid != 10) begin
            errors++;
            $display("FAIL b2b_throughput: got %0d results want 10", nvalid);
        end
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_idle: got in_ready=%b want 1", in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry_chain();
        test_cin();
        test_wrap_ovf();
        test_backpressure();
        test_reset_in_run();
        test_reset_in_done();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
